reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Staged reset controller that consumes the power-on reset and drives ordered, per-stage active-low resets to the downstream pixel-domain blocks: timing generator first, then pixel pipeline, then framebuffer/output. It also accepts a debounced board-button reset and a one-cycle soft-reset request, re-entering the full sequence on either. Each stage is released only after its predecessor has been out of reset for a minimum time and has acknowledged readiness. A timeout prevents a silent stall.

## Interface
- STAGES, 3, number of staged reset outputs (1..8)
- MIN_ASSERT, 64, cycles all outputs are held low before stage 0 release (≥1)
- STAGE_DELAY, 1024, minimum cycles between release of stage k and release of stage k+1 (≥1)
- ACK_TIMEOUT, 65536, cycles after release of stage k before stage k+1 is released without acknowledgement (> STAGE_DELAY)
- DEBOUNCE_BITS, 16, button must be stable for 2^DEBOUNCE_BITS cycles
- clk  in  1  clock (clk_pix)
- reset_n  in  1  reset, synchronous, active-low
- btn_n  in  1  asynchronous board button, active-low
- soft_req  in  1  single-cycle soft-reset request, clk domain
- stage_ack  in  STAGES  per-stage ready, clk domain, level
- rst_out_n  out  STAGES  staged resets, active-low, registered
- busy  out  1  high whenever the state is not RUN
- fault  out  STAGES  sticky: stage k released by timeout, not by ack
- reset_cause  out  2  00 POR, 01 button, 10 soft

## Operation
- Button path: 2-FF synchronizer → debounce counter (resets on any change of synced level; debounced level updates when counter saturates at 2^DEBOUNCE_BITS−1) → falling-edge detect of debounced level gives btn_req, one pulse per press.
- FSM states: ASSERT, RELEASE, RUN. Registers: stage index k, assert counter, delay counter, timeout counter.
- ASSERT: rst_out_n all 0, busy=1. Assert counter increments; on count MIN_ASSERT−1 go to RELEASE with k=0, set rst_out_n[0]=1, clear delay and timeout counters.
- RELEASE(k): delay and timeout counters increment each cycle.
  - Advance when (delay ≥ STAGE_DELAY−1 and stage_ack[k]=1), or when timeout = ACK_TIMEOUT−1.
  - Timeout path sets fault[k]=1.
  - Advance means: if k<STAGES−1, set k=k+1 and rst_out_n[k+1]=1, then clear both counters; otherwise go to RUN.
- RUN: busy=0, outputs all 1. stage_ack is ignored.
- Request (btn_req or soft_req) in any state: next cycle go to ASSERT, all rst_out_n=0, assert counter=0. reset_cause=01 if btn_req (button wins if both are asserted), else 10.
  - fault is cleared on request entry.
  - Requests during ASSERT restart the hold count.
- Released stages never re-assert except on request or reset_n.
- STAGES=1: RELEASE(0) advances directly to RUN under the same condition.

## Timing
- reset_n=0 at an edge gives:
  - state ASSERT, rst_out_n=0, busy=1, fault=0, reset_cause=00
  - all counters 0, synchronizer and debounce registers set to released (1)
- First edge with reset_n=1 is hold cycle 0. rst_out_n[0] rises at the edge ending hold cycle MIN_ASSERT−1, i.e. MIN_ASSERT edges after reset deassertion.
- Stage k+1 rises exactly STAGE_DELAY edges after stage k if ack is already high; otherwise it rises at the edge that samples ack=1. With no ack, it rises ACK_TIMEOUT edges after stage k.
- busy falls one edge after the last stage's advance condition is met. The last stage itself already rose earlier.
- Request to all rst_out_n low takes 1 edge for soft_req. For the button, it is 2 (sync) + 2^DEBOUNCE_BITS (debounce) + 1 edges after btn_n falls.
- reset_n assertion mid-sequence overrides everything at the same edge.

## Test plan
Parameters for all scenarios: STAGES=3, MIN_ASSERT=4, STAGE_DELAY=8, ACK_TIMEOUT=32, DEBOUNCE_BITS=3.
- POR with stage_ack=3'b111: rst_out_n[0] rises at edge 4 after reset_n high, [1] at 12, [2] at 20; busy falls at 28; reset_cause=00; fault=0.
- Late ack: stage_ack[1] held 0 until edge 25 → rst_out_n[2] rises at edge 25, fault=0.
- No ack on stage 0: rst_out_n[1] rises 32 edges after [0], fault=3'b001 sticky through RUN.
- soft_req pulse in RUN: next edge rst_out_n=0, busy=1, reset_cause=10, fault cleared; full sequence repeats with identical spacing.
- Button bounce: btn_n toggles every 3 cycles for 30 cycles → no request. Then held low for 12 cycles → exactly one request, reset_cause=01. Releasing and re-pressing gives a second request.
- Simultaneous soft_req and btn_req, and reset_n asserted in RELEASE(1): cause=01; reset_n forces rst_out_n=0 and cause=00 at the same edge.

Source files
------------

// File: rtl/reset_sequencer_if.sv
// Reset-sequencer control/status bundle: soft request and per-stage acks in,
// staged resets and status out. The master side is the sequencer itself.
interface reset_sequencer_if #(
    parameter int STAGES = 3
);
    logic              soft_req;
    logic [STAGES-1:0] stage_ack;
    logic [STAGES-1:0] rst_out_n;
    logic              busy;
    logic [STAGES-1:0] fault;
    logic [1:0]        reset_cause;

    modport master (
        input  soft_req,
        input  stage_ack,
        output rst_out_n,
        output busy,
        output fault,
        output reset_cause
    );

    modport slave (
        output soft_req,
        output stage_ack,
        input  rst_out_n,
        input  busy,
        input  fault,
        input  reset_cause
    );
endinterface

// File: rtl/reset_sequencer.sv
// Staged reset controller: holds all pixel-domain resets low, then releases
// them in order, gated by minimum spacing and per-stage ready (or a timeout).
module reset_sequencer #(
    parameter int STAGES        = 3,
    parameter int MIN_ASSERT    = 64,
    parameter int STAGE_DELAY   = 1024,
    parameter int ACK_TIMEOUT   = 65536,
    parameter int DEBOUNCE_BITS = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               btn_n,
    reset_sequencer_if.master  bus
);
    localparam int AW = (MIN_ASSERT > 1)  ? $clog2(MIN_ASSERT)  : 1;
    localparam int DW = (STAGE_DELAY > 1) ? $clog2(STAGE_DELAY) : 1;
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int KW = (STAGES > 1)      ? $clog2(STAGES)      : 1;

    localparam logic [AW-1:0] ASSERT_LAST = AW'(MIN_ASSERT - 1);
    localparam logic [DW-1:0] DELAY_LAST  = DW'(STAGE_DELAY - 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(ACK_TIMEOUT - 1);
    localparam logic [KW-1:0] K_LAST      = KW'(STAGES - 1);

    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_BTN  = 2'b01;
    localparam logic [1:0] CAUSE_SOFT = 2'b10;

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_RELEASE,
        ST_RUN
    } state_t;

    // ------------------------------------------------------------------
    // Button path: synchronize, debounce, falling-edge detect
    // ------------------------------------------------------------------
    logic                     btn_meta_reg;
    logic                     btn_sync_reg;
    logic                     db_level_reg;
    logic                     db_level_d_reg;
    logic [DEBOUNCE_BITS-1:0] db_cnt_reg;
    logic                     btn_req;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            btn_meta_reg   <= 1'b1;
            btn_sync_reg   <= 1'b1;
            db_level_reg   <= 1'b1;
            db_level_d_reg <= 1'b1;
            db_cnt_reg     <= '0;
        end else begin
            btn_meta_reg   <= btn_n;
            btn_sync_reg   <= btn_meta_reg;
            db_level_d_reg <= db_level_reg;
            // Counting only while the synced level disagrees with the
            // debounced one; any bounce back restarts the count.
            if (btn_sync_reg != db_level_reg) begin
                if (&db_cnt_reg) begin
                    db_level_reg <= btn_sync_reg;
                    db_cnt_reg   <= '0;
                end else begin
                    db_cnt_reg <= db_cnt_reg + 1'b1;
                end
            end else begin
                db_cnt_reg <= '0;
            end
        end
    end

    assign btn_req = db_level_d_reg & ~db_level_reg;

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    state_t            state_reg,       state_next;
    logic [KW-1:0]     k_reg,           k_next;
    logic [AW-1:0]     assert_cnt_reg,  assert_cnt_next;
    logic [DW-1:0]     delay_cnt_reg,   delay_cnt_next;
    logic [TW-1:0]     timeout_cnt_reg, timeout_cnt_next;
    logic [STAGES-1:0] rst_out_reg,     rst_out_next;
    logic [STAGES-1:0] fault_reg,       fault_next;
    logic [1:0]        cause_reg,       cause_next;

    logic [STAGES-1:0] stage_sel;
    logic              delay_done;
    logic              acked;
    logic              timed_out;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_sel
            assign stage_sel[gi] = (k_reg == KW'(gi));
        end
    endgenerate

    assign delay_done = (delay_cnt_reg == DELAY_LAST);
    assign acked      = |(bus.stage_ack & stage_sel);
    assign timed_out  = (timeout_cnt_reg == TO_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg       <= ST_ASSERT;
            k_reg           <= '0;
            assert_cnt_reg  <= '0;
            delay_cnt_reg   <= '0;
            timeout_cnt_reg <= '0;
            rst_out_reg     <= '0;
            fault_reg       <= '0;
            cause_reg       <= CAUSE_POR;
        end else begin
            state_reg       <= state_next;
            k_reg           <= k_next;
            assert_cnt_reg  <= assert_cnt_next;
            delay_cnt_reg   <= delay_cnt_next;
            timeout_cnt_reg <= timeout_cnt_next;
            rst_out_reg     <= rst_out_next;
            fault_reg       <= fault_next;
            cause_reg       <= cause_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        k_next           = k_reg;
        assert_cnt_next  = assert_cnt_reg;
        delay_cnt_next   = delay_cnt_reg;
        timeout_cnt_next = timeout_cnt_reg;
        rst_out_next     = rst_out_reg;
        fault_next       = fault_reg;
        cause_next       = cause_reg;

        if (btn_req || bus.soft_req) begin
            // A request from any state restarts the whole sequence.
            state_next       = ST_ASSERT;
            k_next           = '0;
            assert_cnt_next  = '0;
            delay_cnt_next   = '0;
            timeout_cnt_next = '0;
            rst_out_next     = '0;
            fault_next       = '0;
            cause_next       = btn_req ? CAUSE_BTN : CAUSE_SOFT;
        end else begin
            case (state_reg)
                ST_ASSERT: begin
                    rst_out_next = '0;
                    if (assert_cnt_reg == ASSERT_LAST) begin
                        state_next       = ST_RELEASE;
                        k_next           = '0;
                        rst_out_next     = STAGES'(1);
                        delay_cnt_next   = '0;
                        timeout_cnt_next = '0;
                    end else begin
                        assert_cnt_next = assert_cnt_reg + 1'b1;
                    end
                end

                ST_RELEASE: begin
                    // Delay saturates; the timeout alone bounds the dwell.
                    if (!delay_done) begin
                        delay_cnt_next = delay_cnt_reg + 1'b1;
                    end
                    timeout_cnt_next = timeout_cnt_reg + 1'b1;
                    if ((delay_done && acked) || timed_out) begin
                        if (!(delay_done && acked)) begin
                            fault_next = fault_reg | stage_sel;
                        end
                        if (k_reg == K_LAST) begin
                            state_next = ST_RUN;
                        end else begin
                            k_next           = k_reg + 1'b1;
                            rst_out_next     = rst_out_reg | (stage_sel << 1);
                            delay_cnt_next   = '0;
                            timeout_cnt_next = '0;
                        end
                    end
                end

                ST_RUN: begin
                    rst_out_next = '1;
                end

                default: begin
                    state_next   = ST_ASSERT;
                    rst_out_next = '0;
                end
            endcase
        end
    end

    assign bus.rst_out_n   = rst_out_reg;
    assign bus.busy        = (state_reg != ST_RUN);
    assign bus.fault       = fault_reg;
    assign bus.reset_cause = cause_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: POR timing, late/missing acks, soft and
// button requests, request priority and reset_n override.
module tb_reset_sequencer;
    localparam int STAGES = 3;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic btn_n   = 1'b1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reset_sequencer_if #(.STAGES(STAGES)) bus ();

    reset_sequencer #(
        .STAGES        (STAGES),
        .MIN_ASSERT    (4),
        .STAGE_DELAY   (8),
        .ACK_TIMEOUT   (32),
        .DEBOUNCE_BITS (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_n   (btn_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edges are numbered from 1 after the call. Before e_req the block is
    // expected to still be in RUN; afterwards stage k is high from edge ek
    // and busy is high until edge eb.
    task automatic run_seq(input string tag, input int e_req, input int e0, input int e1,
                           input int e2, input int eb, input int n, input int ack_edge,
                           input logic [2:0] ack_val, input int btn_edge);
        logic [2:0] exp_rst;
        logic       exp_busy;
        for (int e = 1; e <= n; e++) begin
            tick();
            if (e < e_req) begin
                exp_rst  = 3'b111;
                exp_busy = 1'b0;
            end else begin
                exp_rst  = {e >= e2, e >= e1, e >= e0};
                exp_busy = (e < eb);
            end
            check($sformatf("%s rst_out_n@%0d", tag, e), 32'(bus.rst_out_n), 32'(exp_rst));
            check($sformatf("%s busy@%0d", tag, e), 32'(bus.busy), 32'(exp_busy));
            if (e == ack_edge) bus.stage_ack = ack_val;
            if (e == btn_edge) btn_n = 1'b1;
        end
        $display("%s: %0d edges, fault=%b cause=%b", tag, n, bus.fault, bus.reset_cause);
    endtask

    initial begin
        bus.soft_req  = 1'b0;
        bus.stage_ack = 3'b111;

        // Reset state
        repeat (3) tick();
        check("reset rst_out_n", 32'(bus.rst_out_n), 32'h0);
        check("reset busy", 32'(bus.busy), 32'h1);
        check("reset fault", 32'(bus.fault), 32'h0);
        check("reset cause", 32'(bus.reset_cause), 32'h0);
        $display("reset: rst_out_n=%b busy=%b", bus.rst_out_n, bus.busy);

        // POR with all acks high
        reset_n = 1'b1;
        run_seq("por", 0, 4, 12, 20, 28, 32, -1, 3'b000, -1);
        check("por cause", 32'(bus.reset_cause), 32'h0);
        check("por fault", 32'(bus.fault), 32'h0);

        // Late ack on stage 1: sampled high at edge 25
        reset_n = 1'b0;
        tick();
        bus.stage_ack = 3'b101;
        reset_n = 1'b1;
        run_seq("late_ack", 0, 4, 12, 25, 33, 36, 24, 3'b111, -1);
        check("late_ack fault", 32'(bus.fault), 32'h0);

        // No ack on stage 0: released by timeout, fault sticky
        reset_n = 1'b0;
        tick();
        bus.stage_ack = 3'b110;
        reset_n = 1'b1;
        run_seq("no_ack", 0, 4, 36, 44, 52, 56, -1, 3'b000, -1);
        check("no_ack fault", 32'(bus.fault), 32'h1);
        repeat (10) tick();
        check("no_ack fault sticky", 32'(bus.fault), 32'h1);
        check("no_ack busy run", 32'(bus.busy), 32'h0);

        // Soft request in RUN
        bus.stage_ack = 3'b111;
        bus.soft_req  = 1'b1;
        tick();
        bus.soft_req  = 1'b0;
        check("soft rst_out_n", 32'(bus.rst_out_n), 32'h0);
        check("soft busy", 32'(bus.busy), 32'h1);
        check("soft fault cleared", 32'(bus.fault), 32'h0);
        check("soft cause", 32'(bus.reset_cause), 32'h2);
        run_seq("soft", 0, 4, 12, 20, 28, 32, -1, 3'b000, -1);

        // Button bounce: 3-cycle runs never satisfy the debounce
        for (int i = 0; i < 30; i++) begin
            btn_n = (((i / 3) % 2) == 1);
            tick();
            check($sformatf("bounce busy@%0d", i), 32'(bus.busy), 32'h0);
        end
        btn_n = 1'b1;
        $display("bounce: 30 cycles, busy=%b", bus.busy);

        // Clean press: request lands 2+8+1 edges after btn_n falls
        btn_n = 1'b0;
        run_seq("btn1", 11, 15, 23, 31, 39, 44, -1, 3'b000, 12);
        check("btn1 cause", 32'(bus.reset_cause), 32'h1);
        btn_n = 1'b0;
        run_seq("btn2", 11, 15, 23, 31, 39, 44, -1, 3'b000, 12);
        check("btn2 cause", 32'(bus.reset_cause), 32'h1);

        // Soft first so the cause is 10, then button and soft together
        bus.soft_req = 1'b1;
        tick();
        bus.soft_req = 1'b0;
        check("pre_both cause", 32'(bus.reset_cause), 32'h2);
        btn_n = 1'b0;
        repeat (10) tick();
        check("pre_both rst_out_n", 32'(bus.rst_out_n), 32'h1);
        bus.soft_req = 1'b1;
        tick();
        bus.soft_req = 1'b0;
        btn_n = 1'b1;
        check("both cause", 32'(bus.reset_cause), 32'h1);
        check("both rst_out_n", 32'(bus.rst_out_n), 32'h0);
        $display("both: cause=%b rst_out_n=%b", bus.reset_cause, bus.rst_out_n);

        // reset_n asserted in RELEASE(1)
        repeat (4) tick();
        check("both stage0", 32'(bus.rst_out_n), 32'h1);
        repeat (10) tick();
        check("release1 rst_out_n", 32'(bus.rst_out_n), 32'h3);
        check("release1 busy", 32'(bus.busy), 32'h1);
        reset_n = 1'b0;
        tick();
        check("override rst_out_n", 32'(bus.rst_out_n), 32'h0);
        check("override cause", 32'(bus.reset_cause), 32'h0);
        check("override busy", 32'(bus.busy), 32'h1);
        check("override fault", 32'(bus.fault), 32'h0);
        $display("override: rst_out_n=%b cause=%b", bus.rst_out_n, bus.reset_cause);
        reset_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
